// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b memory arbiter: bus widths, arbitration state and grant encodings.
package lc3b_mem_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int MASK_W = DATA_W / 8;

    typedef logic [DATA_W-1:0] lc3b_word;
    typedef logic [MASK_W-1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } lc3b_arb_grant;

    localparam lc3b_mem_wmask WMASK_ALL = '1;

endpackage

// File: rtl/lc3b_mem_arbiter_if.sv
// Requester and physical-memory signals of the arbiter, grouped as one bundle.
// Handshake: a requester holds read/write until its resp pulses for one cycle; pmem_resp is a one-cycle pulse.
interface lc3b_mem_arbiter_if;
    import lc3b_mem_arbiter_pkg::*;

    logic          i_read;
    lc3b_word      i_addr;
    lc3b_word      i_rdata;
    logic          i_resp;

    logic          d_read;
    logic          d_write;
    lc3b_word      d_addr;
    lc3b_word      d_wdata;
    lc3b_mem_wmask d_wmask;
    lc3b_word      d_rdata;
    logic          d_resp;

    logic          pmem_read;
    logic          pmem_write;
    lc3b_word      pmem_addr;
    lc3b_word      pmem_wdata;
    lc3b_mem_wmask pmem_wmask;
    lc3b_word      pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
        input  pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_wmask
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
        output pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata, pmem_wmask
    );

endinterface

// File: rtl/lc3b_mem_arbiter_watchdog.sv
// Saturating transaction watchdog: clears on grant, counts busy cycles, flags terminal count.
module lc3b_arb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TC_VAL)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // TIMEOUT of zero leaves the counter parked at zero and the flag low.
    assign o_tc = (TIMEOUT != 0) && (r_cnt == TC_VAL);

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between instruction fetch and data access.
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    lc3b_mem_arbiter_if.slave    bus,
    output logic                 timeout_err,
    output lc3b_arb_state        o_dbg_state
);

    lc3b_arb_state r_state;
    lc3b_arb_grant r_last_grant;
    logic          r_pmem_read;
    logic          r_pmem_write;
    lc3b_word      r_pmem_addr;
    lc3b_word      r_pmem_wdata;
    lc3b_mem_wmask r_pmem_wmask;
    logic          r_timeout_err;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_busy;
    logic w_wd_tc;
    logic w_done;

    assign w_i_req   = bus.i_read;
    assign w_d_req   = bus.d_read | bus.d_write;
    // On a tie, the requester that did not win last time gets the port.
    assign w_grant_i = (r_state == IDLE) && w_i_req && (!w_d_req || (r_last_grant == GRANT_D));
    assign w_grant_d = (r_state == IDLE) && w_d_req && !w_grant_i;
    assign w_busy    = (r_state != IDLE);
    assign w_done    = w_busy && (bus.pmem_resp || w_wd_tc);

    lc3b_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_grant_i | w_grant_d),
        .i_en    (w_busy & ~bus.pmem_resp),
        .o_tc    (w_wd_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_D;
            r_pmem_read   <= 1'b0;
            r_pmem_write  <= 1'b0;
            r_pmem_addr   <= '0;
            r_pmem_wdata  <= '0;
            r_pmem_wmask  <= WMASK_ALL;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state      <= BUSY_I;
                        r_last_grant <= GRANT_I;
                        r_pmem_read  <= 1'b1;
                        r_pmem_write <= 1'b0;
                        r_pmem_addr  <= bus.i_addr;
                        r_pmem_wmask <= WMASK_ALL;
                    end else if (w_grant_d) begin
                        // A simultaneous read+write request is serviced as a write.
                        r_state      <= BUSY_D;
                        r_last_grant <= GRANT_D;
                        r_pmem_read  <= ~bus.d_write;
                        r_pmem_write <= bus.d_write;
                        r_pmem_addr  <= bus.d_addr;
                        r_pmem_wdata <= bus.d_wdata;
                        r_pmem_wmask <= bus.d_write ? bus.d_wmask : WMASK_ALL;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (w_done) begin
                        r_state      <= IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (!bus.pmem_resp) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.i_resp     = (r_state == BUSY_I) && (bus.pmem_resp || w_wd_tc);
    assign bus.d_resp     = (r_state == BUSY_D) && (bus.pmem_resp || w_wd_tc);
    assign bus.i_rdata    = bus.pmem_rdata;
    assign bus.d_rdata    = bus.pmem_rdata;
    assign bus.pmem_read  = r_pmem_read;
    assign bus.pmem_write = r_pmem_write;
    assign bus.pmem_addr  = r_pmem_addr;
    assign bus.pmem_wdata = r_pmem_wdata;
    assign bus.pmem_wmask = r_pmem_wmask;
    assign timeout_err    = r_timeout_err;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Directed bench for the LC-3b memory arbiter with a short watchdog.
module tb_lc3b_mem_arbiter;
    import lc3b_mem_arbiter_pkg::*;

    logic          clk;
    logic          reset_n;
    logic          timeout_err;
    lc3b_arb_state dbg_state;
    int            n_checks;
    int            n_errors;

    lc3b_mem_arbiter_if bus ();

    lc3b_mem_arbiter #(
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .timeout_err (timeout_err),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE); end
        n_checks++; if (bus.pmem_read !== 1'b0) begin n_errors++; $display("FAIL reset_read: got %b want 0", bus.pmem_read); end
        n_checks++; if (bus.pmem_write !== 1'b0) begin n_errors++; $display("FAIL reset_write: got %b want 0", bus.pmem_write); end
        n_checks++; if (bus.pmem_addr !== 16'h0000) begin n_errors++; $display("FAIL reset_addr: got %h want 0000", bus.pmem_addr); end
        n_checks++; if (bus.pmem_wdata !== 16'h0000) begin n_errors++; $display("FAIL reset_wdata: got %h want 0000", bus.pmem_wdata); end
        n_checks++; if (bus.pmem_wmask !== 2'b11) begin n_errors++; $display("FAIL reset_wmask: got %b want 11", bus.pmem_wmask); end
        n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", timeout_err); end
        n_checks++; if ({bus.i_resp, bus.d_resp} !== 2'b00) begin n_errors++; $display("FAIL reset_resp: got %b want 00", {bus.i_resp, bus.d_resp}); end
        reset_n = 1'b1;
    endtask

    task automatic test_single_i();
        bus.i_read = 1'b1;
        bus.i_addr = 16'h0010;
        @(negedge clk);
        n_checks++; if (bus.pmem_read !== 1'b1) begin n_errors++; $display("FAIL single_i_read: got %b want 1", bus.pmem_read); end
        n_checks++; if (bus.pmem_addr !== 16'h0010) begin n_errors++; $display("FAIL single_i_addr: got %h want 0010", bus.pmem_addr); end
        n_checks++; if (bus.pmem_wmask !== 2'b11) begin n_errors++; $display("FAIL single_i_wmask: got %b want 11", bus.pmem_wmask); end
        n_checks++; if (bus.i_resp !== 1'b0) begin n_errors++; $display("FAIL single_i_early_resp: got %b want 0", bus.i_resp); end
        repeat (2) @(negedge clk);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h1234;
        #1;
        n_checks++; if (bus.i_resp !== 1'b1) begin n_errors++; $display("FAIL single_i_resp: got %b want 1", bus.i_resp); end
        n_checks++; if (bus.i_rdata !== 16'h1234) begin n_errors++; $display("FAIL single_i_rdata: got %h want 1234", bus.i_rdata); end
        n_checks++; if (bus.d_resp !== 1'b0) begin n_errors++; $display("FAIL single_i_dresp: got %b want 0", bus.d_resp); end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        n_checks++; if (bus.pmem_read !== 1'b0) begin n_errors++; $display("FAIL single_i_drop: got %b want 0", bus.pmem_read); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL single_i_idle: got %0d want %0d", dbg_state, IDLE); end
    endtask

    task automatic test_write_hold();
        bus.d_write = 1'b1;
        bus.d_addr  = 16'h0201;
        bus.d_wdata = 16'h00AB;
        bus.d_wmask = 2'b10;
        @(negedge clk);
        n_checks++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin n_errors++; $display("FAIL write_strobes: got %b want 10", {bus.pmem_write, bus.pmem_read}); end
        n_checks++; if (bus.pmem_addr !== 16'h0201) begin n_errors++; $display("FAIL write_addr: got %h want 0201", bus.pmem_addr); end
        n_checks++; if (bus.pmem_wdata !== 16'h00AB) begin n_errors++; $display("FAIL write_wdata: got %h want 00ab", bus.pmem_wdata); end
        n_checks++; if (bus.pmem_wmask !== 2'b10) begin n_errors++; $display("FAIL write_wmask: got %b want 10", bus.pmem_wmask); end
        bus.d_addr  = 16'hFFFF;
        bus.d_wdata = 16'h5555;
        bus.d_wmask = 2'b01;
        @(negedge clk);
        n_checks++; if (bus.pmem_addr !== 16'h0201) begin n_errors++; $display("FAIL write_hold_addr: got %h want 0201", bus.pmem_addr); end
        n_checks++; if (bus.pmem_wdata !== 16'h00AB) begin n_errors++; $display("FAIL write_hold_wdata: got %h want 00ab", bus.pmem_wdata); end
        n_checks++; if (bus.pmem_wmask !== 2'b10) begin n_errors++; $display("FAIL write_hold_wmask: got %b want 10", bus.pmem_wmask); end
        bus.pmem_resp = 1'b1;
        #1;
        n_checks++; if ({bus.d_resp, bus.i_resp} !== 2'b10) begin n_errors++; $display("FAIL write_resp: got %b want 10", {bus.d_resp, bus.i_resp}); end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.d_write   = 1'b0;
        n_checks++; if (bus.pmem_write !== 1'b0) begin n_errors++; $display("FAIL write_drop: got %b want 0", bus.pmem_write); end
    endtask

    task automatic test_rw_conflict();
        bus.d_read  = 1'b1;
        bus.d_write = 1'b1;
        bus.d_addr  = 16'h0400;
        bus.d_wdata = 16'h1111;
        bus.d_wmask = 2'b01;
        @(negedge clk);
        n_checks++; if ({bus.pmem_write, bus.pmem_read} !== 2'b10) begin n_errors++; $display("FAIL rw_strobes: got %b want 10", {bus.pmem_write, bus.pmem_read}); end
        n_checks++; if (bus.pmem_wmask !== 2'b01) begin n_errors++; $display("FAIL rw_wmask: got %b want 01", bus.pmem_wmask); end
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
    endtask

    task automatic test_round_robin();
        logic exp_i;
        reset_n = 1'b0;
        @(negedge clk);
        reset_n    = 1'b1;
        bus.i_read = 1'b1;
        bus.i_addr = 16'h0100;
        bus.d_read = 1'b1;
        bus.d_addr = 16'h0200;
        for (int t = 0; t < 4; t++) begin
            exp_i = (t % 2 == 0);
            @(negedge clk);
            n_checks++; if (dbg_state !== (exp_i ? BUSY_I : BUSY_D)) begin n_errors++; $display("FAIL rr_state[%0d]: got %0d want %0d", t, dbg_state, exp_i ? BUSY_I : BUSY_D); end
            n_checks++; if (bus.pmem_addr !== (exp_i ? 16'h0100 : 16'h0200)) begin n_errors++; $display("FAIL rr_addr[%0d]: got %h want %h", t, bus.pmem_addr, exp_i ? 16'h0100 : 16'h0200); end
            bus.pmem_resp  = 1'b1;
            bus.pmem_rdata = 16'h1000 + 16'(t);
            #1;
            n_checks++; if ({bus.i_resp, bus.d_resp} !== {exp_i, ~exp_i}) begin n_errors++; $display("FAIL rr_resp[%0d]: got %b want %b", t, {bus.i_resp, bus.d_resp}, {exp_i, ~exp_i}); end
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            n_checks++; if ({dbg_state, bus.pmem_read} !== {IDLE, 1'b0}) begin n_errors++; $display("FAIL rr_turnaround[%0d]: got %0d/%b want %0d/0", t, dbg_state, bus.pmem_read, IDLE); end
        end
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
    endtask

    task automatic test_timeout();
        bus.d_read     = 1'b1;
        bus.d_addr     = 16'h0300;
        bus.pmem_rdata = 16'hBEEF;
        @(negedge clk);
        n_checks++; if (dbg_state !== BUSY_D) begin n_errors++; $display("FAIL to_state: got %0d want %0d", dbg_state, BUSY_D); end
        for (int k = 1; k <= 4; k++) begin
            n_checks++; if (bus.d_resp !== 1'b0) begin n_errors++; $display("FAIL to_early_resp[%0d]: got %b want 0", k, bus.d_resp); end
            @(negedge clk);
        end
        n_checks++; if (bus.d_resp !== 1'b1) begin n_errors++; $display("FAIL to_resp: got %b want 1", bus.d_resp); end
        n_checks++; if (bus.d_rdata !== 16'hBEEF) begin n_errors++; $display("FAIL to_rdata: got %h want beef", bus.d_rdata); end
        bus.d_read = 1'b0;
        @(negedge clk);
        n_checks++; if (timeout_err !== 1'b1) begin n_errors++; $display("FAIL to_err: got %b want 1", timeout_err); end
        n_checks++; if ({dbg_state, bus.pmem_read} !== {IDLE, 1'b0}) begin n_errors++; $display("FAIL to_idle: got %0d/%b want %0d/0", dbg_state, bus.pmem_read, IDLE); end
        bus.i_read = 1'b1;
        bus.i_addr = 16'h0020;
        @(negedge clk);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'h7777;
        #1;
        n_checks++; if (bus.i_resp !== 1'b1) begin n_errors++; $display("FAIL to_next_resp: got %b want 1", bus.i_resp); end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        n_checks++; if (timeout_err !== 1'b1) begin n_errors++; $display("FAIL to_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        bus.d_write = 1'b1;
        bus.d_addr  = 16'h0500;
        bus.d_wmask = 2'b11;
        @(negedge clk);
        n_checks++; if (bus.pmem_write !== 1'b1) begin n_errors++; $display("FAIL rm_busy: got %b want 1", bus.pmem_write); end
        bus.i_read = 1'b1;
        bus.i_addr = 16'h0030;
        reset_n    = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.pmem_read, bus.pmem_write} !== 2'b00) begin n_errors++; $display("FAIL rm_strobes: got %b want 00", {bus.pmem_read, bus.pmem_write}); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL rm_state: got %0d want %0d", dbg_state, IDLE); end
        n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL rm_err: got %b want 0", timeout_err); end
        reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dbg_state !== BUSY_I) begin n_errors++; $display("FAIL rm_first_grant: got %0d want %0d", dbg_state, BUSY_I); end
        n_checks++; if (bus.pmem_addr !== 16'h0030) begin n_errors++; $display("FAIL rm_addr: got %h want 0030", bus.pmem_addr); end
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        bus.d_write   = 1'b0;
    endtask

    task automatic test_resp_at_timeout();
        bus.i_read = 1'b1;
        bus.i_addr = 16'h0040;
        @(negedge clk);
        n_checks++; if (dbg_state !== BUSY_I) begin n_errors++; $display("FAIL rt_state: got %0d want %0d", dbg_state, BUSY_I); end
        repeat (4) @(negedge clk);
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = 16'hCAFE;
        #1;
        n_checks++; if (bus.i_resp !== 1'b1) begin n_errors++; $display("FAIL rt_resp: got %b want 1", bus.i_resp); end
        n_checks++; if (bus.i_rdata !== 16'hCAFE) begin n_errors++; $display("FAIL rt_rdata: got %h want cafe", bus.i_rdata); end
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        bus.i_read    = 1'b0;
        n_checks++; if (timeout_err !== 1'b0) begin n_errors++; $display("FAIL rt_err: got %b want 0", timeout_err); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL rt_idle: got %0d want %0d", dbg_state, IDLE); end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset_n        = 1'b0;
        bus.i_read     = 1'b0;
        bus.i_addr     = '0;
        bus.d_read     = 1'b0;
        bus.d_write    = 1'b0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.d_wmask    = '0;
        bus.pmem_rdata = '0;
        bus.pmem_resp  = 1'b0;
        test_reset();
        test_single_i();
        test_write_hold();
        test_rw_conflict();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_resp_at_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
